// File: rtl/fanin_collector.sv
// fanin_collector: captures a LANES-wide sample, takes a strict-majority
// vote over the participating lanes, holds the result until it is
// consumed, and keeps a saturating count of samples whose lanes disagree.
//
// Optional feature macro: FANIN_LANE_MASK_EN
//   defined   -> adds input lane_mask (1 = lane excluded), captured with in_bits
//   undefined -> every lane participates

// Per-lane qualifier: whether the lane takes part in the vote and
// whether it contributes a one.
module fanin_collector_lane (
    input  logic smp,
    input  logic msk,
    output logic part,
    output logic one
);
    assign part = ~msk;
    assign one  = smp & ~msk;
endmodule

module fanin_collector #(
    parameter int LANES = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [LANES-1:0] in_bits,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_mismatch,
`ifdef FANIN_LANE_MASK_EN
    input  logic [LANES-1:0] lane_mask,
`endif
    output logic [CNT_W-1:0] err_count
);
    // Counter width wide enough to hold LANES itself.
    localparam int CW = $clog2(LANES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] VOTE = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [LANES-1:0] sample_q;
    logic [LANES-1:0] mask_v;
    logic [LANES-1:0] part_v;
    logic [LANES-1:0] one_v;
    logic [CW-1:0]    p_cnt;
    logic [CW-1:0]    n_cnt;
    logic             maj;
    logic             mis;
    logic             out_bit_q;
    logic             out_mis_q;
    logic [CNT_W-1:0] err_q;
    logic             accept;

`ifdef FANIN_LANE_MASK_EN
    logic [LANES-1:0] mask_q;

    // Lane mask is captured alongside the sample so it stays aligned with it.
    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= '0;
        else if (accept)
            mask_q <= lane_mask;
    end

    assign mask_v = mask_q;
`else
    assign mask_v = '0;
`endif

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign out_bit      = out_bit_q;
    assign out_mismatch = out_mis_q;
    assign err_count    = err_q;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            fanin_collector_lane u_lane (
                .smp  (sample_q[g]),
                .msk  (mask_v[g]),
                .part (part_v[g]),
                .one  (one_v[g])
            );
        end
    endgenerate

    // Popcount of ones (P) and of participating lanes (N).
    always_comb begin
        p_cnt = '0;
        n_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            p_cnt = p_cnt + CW'(one_v[i]);
            n_cnt = n_cnt + CW'(part_v[i]);
        end
    end

    // Strict majority (ties lose); mismatch when lanes are not unanimous.
    // N=0 forces P=0, so both come out 0 with no special case.
    assign maj = ({p_cnt, 1'b0} > {1'b0, n_cnt});
    assign mis = (p_cnt != '0) && (p_cnt != n_cnt);

    // Control FSM: IDLE accepts, VOTE is a single evaluation cycle, HOLD
    // waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= VOTE;
                VOTE:    state <= HOLD;
                HOLD:    if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sample capture on accept.
    always_ff @(posedge clk) begin
        if (rst)
            sample_q <= '0;
        else if (accept)
            sample_q <= in_bits;
    end

    // Result registers load once on VOTE->HOLD and stay put through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bit_q <= 1'b0;
            out_mis_q <= 1'b0;
        end else if (state == VOTE) begin
            out_bit_q <= maj;
            out_mis_q <= mis;
        end
    end

    // Saturating mismatch counter, bumped on VOTE->HOLD only.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else if (state == VOTE && mis && err_q != '1)
            err_q <= err_q + 1'b1;
    end
endmodule

// File: doc/fanin_collector.md
FANIN_COLLECTOR -- requirements
Module: fanin_collector

Interface
REQ-001 The block SHALL have parameter LANES, default 12: number of captured input lanes (legal range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the mismatch counter.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1: a sample is present on in_bits.
REQ-006 The block SHALL have port in_bits, input, LANES: one bit per capture register.
REQ-007 The block SHALL have port in_ready, output, 1: the block accepts a sample this cycle.
REQ-008 The block SHALL have port out_valid, output, 1: a result is held on the out_* ports.
REQ-009 The block SHALL have port out_ready, input, 1: the downstream consumer takes the result.
REQ-010 The block SHALL have port out_bit, output, 1: majority value of the accepted sample.
REQ-011 The block SHALL have port out_mismatch, output, 1: at least one participating lane differs from out_bit.
REQ-012 The block SHALL have port err_count, output, CNT_W: saturating count of mismatching samples.

Function
REQ-013 The FSM SHALL have three states (IDLE, VOTE, HOLD); in_ready SHALL be 1 only in IDLE.
REQ-014 Accept = in_valid && in_ready; on accept, in_bits SHALL be registered and the state SHALL go IDLE->VOTE; in_valid with in_ready=0 SHALL be ignored.
REQ-015 VOTE SHALL last exactly one cycle and compute the popcount P of participating lanes set to 1 over N participating lanes, then go to HOLD.
REQ-016 out_bit SHALL be 1 iff 2*P > N (strict majority); ties (even N) SHALL give 0.
REQ-017 out_mismatch SHALL be 1 iff 0 < P < N.
REQ-018 In HOLD, out_valid SHALL be 1 and out_bit/out_mismatch SHALL remain stable until out_ready=1; on that cycle the state SHALL return to IDLE and out_valid SHALL fall the next cycle.
REQ-019 Latency SHALL be: accept on cycle k gives out_valid=1 from cycle k+2; minimum initiation interval SHALL be 3 cycles.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 err_count SHALL increment by 1 on the VOTE->HOLD transition when out_mismatch is 1, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-022 If N=0, then out_bit=0, out_mismatch=0, and err_count SHALL NOT increment.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set state=IDLE, out_valid=0, out_bit=0, out_mismatch=0, err_count=0, and the sample register to 0; in_ready SHALL be 1 from the cycle after reset.
REQ-024 Reset in VOTE or HOLD SHALL discard the pending result with no increment; reset SHALL take priority over a simultaneous accept or out_ready.

Configuration
REQ-025 The block SHALL implement macro FANIN_LANE_MASK_EN as follows. Defined: the block adds input port lane_mask (LANES bits, 1 = lane excluded), sampled together with in_bits on accept; masked lanes are excluded from P and N. Undefined: no lane_mask port; N = LANES and all lanes participate.

Verification
REQ-026 The bench SHALL drive reset, then in_bits=12'hFFF accepted on cycle 0 with out_ready=1, and SHALL check out_valid=1 on cycle 2 with out_bit=1, out_mismatch=0, err_count=0.
REQ-027 The bench SHALL drive in_bits=12'h03F (tie, 6 of 12) and SHALL check out_bit=0, out_mismatch=1, err_count=1.
REQ-028 The bench SHALL hold out_ready=0 for 5 cycles in HOLD while toggling in_valid/in_bits, and SHALL check that outputs are stable, in_ready=0, and the sample is taken after release.
REQ-029 With CNT_W=2, the bench SHALL drive 5 mismatching samples and SHALL check that err_count reads 1,2,3,3,3.
REQ-030 The bench SHALL assert rst in HOLD with a mismatching result, and SHALL check out_valid=0, err_count=0, and in_ready=1 on the following cycle.
REQ-031 With FANIN_LANE_MASK_EN defined, the bench SHALL drive lane_mask=12'hFF0 and in_bits=12'h00E (P=3, N=4), and SHALL check out_bit=1 and out_mismatch=1; with lane_mask=12'hFFF it SHALL check out_bit=0, out_mismatch=0, and no increment.
